// File: rtl/cc_operand_loader.sv
// Serial-to-parallel operand loader feeding the 4-operand compare/sort stage.
// Optional partial-frame timeout is enabled by defining CC_LOADER_TIMEOUT_EN.
module cc_operand_loader #(
  parameter int DATA_W      = 4,
  parameter int OPT_W       = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OPT_W-1:0]  in_opt,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_n0,
  output logic [DATA_W-1:0] out_n1,
  output logic [DATA_W-1:0] out_n2,
  output logic [DATA_W-1:0] out_n3,
  output logic [OPT_W-1:0]  out_opt,
  output logic [7:0]        frame_cnt,
  output logic              abort
);

  generate
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("cc_operand_loader: TIMEOUT_CYC must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  state_t                      r_state;
  logic [1:0]                  r_idx;
  logic [3:0][DATA_W-1:0]      r_n;
  logic [OPT_W-1:0]            r_opt;
  logic                        r_out_valid;
  logic [7:0]                  r_frame_cnt;
  logic                        w_accept;
  logic                        w_release;

  // In FULL the slot-0 write for the next frame coincides with the release,
  // so accepting is only safe when downstream takes the current frame.
  assign in_ready  = (r_state != S_FULL) | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_release = (r_state == S_FULL) & out_ready;

`ifdef CC_LOADER_TIMEOUT_EN
  logic [7:0] r_idle;
  logic       r_abort;
  assign abort = r_abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_n         <= '0;
      r_opt       <= '0;
      r_out_valid <= 1'b0;
      r_frame_cnt <= 8'd0;
`ifdef CC_LOADER_TIMEOUT_EN
      r_idle      <= 8'd0;
      r_abort     <= 1'b0;
`endif
    end else begin
`ifdef CC_LOADER_TIMEOUT_EN
      r_abort <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n[0]  <= in_data;
            r_opt   <= in_opt;
            r_idx   <= 2'd1;
            r_state <= S_LOAD;
`ifdef CC_LOADER_TIMEOUT_EN
            r_idle  <= 8'd0;
`endif
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_n[r_idx] <= in_data;
`ifdef CC_LOADER_TIMEOUT_EN
            r_idle     <= 8'd0;
`endif
            if (r_idx == 2'd3) begin
              r_idx       <= 2'd0;
              r_out_valid <= 1'b1;
              r_state     <= S_FULL;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
`ifdef CC_LOADER_TIMEOUT_EN
          else if (r_idle == 8'(TIMEOUT_CYC - 1)) begin
            r_idle  <= 8'd0;
            r_idx   <= 2'd0;
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idle <= r_idle + 8'd1;
          end
`endif
        end
        S_FULL: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_accept) begin
              r_n[0]  <= in_data;
              r_opt   <= in_opt;
              r_idx   <= 2'd1;
              r_state <= S_LOAD;
`ifdef CC_LOADER_TIMEOUT_EN
              r_idle  <= 8'd0;
`endif
            end else begin
              r_idx   <= 2'd0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_idx       <= 2'd0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_n0    = r_n[0];
  assign out_n1    = r_n[1];
  assign out_n2    = r_n[2];
  assign out_n3    = r_n[3];
  assign out_opt   = r_opt;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cc_operand_loader.sv
// Directed bench for cc_operand_loader with a frame scoreboard checked at each release.
module tb_cc_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic [2:0] in_opt;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_n0, out_n1, out_n2, out_n3;
  logic [2:0] out_opt;
  logic [7:0] frame_cnt;
  logic       abort;

  cc_operand_loader #(.DATA_W(4), .OPT_W(3), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_opt(in_opt),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_n0(out_n0), .out_n1(out_n1), .out_n2(out_n2), .out_n3(out_n3),
    .out_opt(out_opt), .frame_cnt(frame_cnt), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][3:0] n;
    logic [2:0]      opt;
  } frame_t;

  frame_t     q[$];
  frame_t     cur;
  int         tb_idx  = 0;
  logic [7:0] exp_cnt = 8'd0;
  int         n_cmp   = 0;
  int         n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the operand is taken.
  task automatic send(input logic [3:0] d, input logic [2:0] o);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_opt = o;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (tb_idx == 0) cur.opt = o;
    cur.n[tb_idx] = d;
    tb_idx++;
    if (tb_idx == 4) begin q.push_back(cur); tb_idx = 0; end
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    q.delete(); tb_idx = 0; exp_cnt = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: pop scoreboard on each release and check holds during stalls.
  logic        pv = 1'b0, phs = 1'b0;
  logic [18:0] snap;
  always @(negedge clk) begin
    frame_t e;
    if (rst) begin
      pv = 1'b0; phs = 1'b0;
    end else begin
      if (pv && !phs) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_n3, out_n2, out_n1, out_n0, out_opt}, snap);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("n0", out_n0, e.n[0]);
          check("n1", out_n1, e.n[1]);
          check("n2", out_n2, e.n[2]);
          check("n3", out_n3, e.n[3]);
          check("opt", out_opt, e.opt);
          check("frame_cnt", frame_cnt, exp_cnt);
        end
        exp_cnt = exp_cnt + 8'd1;
      end
      pv   = out_valid;
      phs  = out_valid && out_ready;
      snap = {out_n3, out_n2, out_n1, out_n0, out_opt};
    end
  end

  initial begin
    int n;
    int n_ab;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_opt = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_n", {out_n3, out_n2, out_n1, out_n0}, 0);
    check("rst_opt", out_opt, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_abort", abort, 0);
    rst = 1'b0; #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // First frame, latency and count
    send(4'd3, 3'b101); send(4'd9, 3'd0); send(4'd0, 3'd0); send(4'd15, 3'd0);
    check("latency", out_valid, 1);
    @(posedge clk); #1;
    check("cnt_after_1", frame_cnt, 1);
    check("valid_drop", out_valid, 0);

    // Back-to-back frames, no bubble
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) send(4'($urandom), 3'($urandom));
      check("b2b_valid", out_valid, 1);
    end
    repeat (2) @(posedge clk); #1;

    // Stall in FULL, then release with next n0 accepted same cycle
    out_ready = 1'b0;
    send(4'd1, 3'd6); send(4'd2, 3'd0); send(4'd4, 3'd0); send(4'd8, 3'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(4'd7, 3'd2);
    check("post_release_valid", out_valid, 0);
    send(4'd6, 3'd0); send(4'd5, 3'd0); send(4'd4, 3'd0);
    check("stall_next_valid", out_valid, 1);
    repeat (2) @(posedge clk); #1;

    // Reset mid-frame
    send(4'd10, 3'd1); send(4'd11, 3'd0);
    rst = 1'b1; #1;
    check("mid_rst_n", {out_n3, out_n2, out_n1, out_n0}, 0);
    check("mid_rst_opt", out_opt, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_valid", out_valid, 0);
    q.delete(); tb_idx = 0; exp_cnt = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(4'd12, 3'd3); send(4'd13, 3'd0); send(4'd14, 3'd0); send(4'd15, 3'd0);
    @(posedge clk); #1;
    check("clean_frame_cnt", frame_cnt, 1);

    // 256 frames wrap the counter
    do_reset();
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < 4; k++) send(4'($urandom), 3'($urandom));
    repeat (2) @(posedge clk); #1;
    check("wrap_cnt", frame_cnt, 0);

`ifdef CC_LOADER_TIMEOUT_EN
    // 15 idle cycles abort the partial frame
    send(4'd1, 3'd1); send(4'd2, 3'd0);
    n_ab = 0;
    repeat (20) begin @(negedge clk); if (abort === 1'b1) n_ab++; end
    check("abort_pulses", n_ab, 1);
    check("abort_cnt_hold", frame_cnt, exp_cnt);
    tb_idx = 0;
    @(posedge clk); #1;
    send(4'd9, 3'd4); send(4'd8, 3'd0); send(4'd7, 3'd0); send(4'd6, 3'd0);
    repeat (2) @(posedge clk); #1;
    // 14 idle cycles do not
    n_ab = 0;
    send(4'd3, 3'd2); send(4'd4, 3'd0);
    repeat (14) begin @(posedge clk); #1; if (abort === 1'b1) n_ab++; end
    send(4'd5, 3'd0); send(4'd6, 3'd0);
    check("no_abort", n_ab, 0);
    repeat (2) @(posedge clk); #1;
`endif

    n = 0;
    while (q.size() != 0 && n < 20) begin n++; @(posedge clk); #1; end
    check("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cc_operand_loader.md
Name: cc_operand_loader

Overview:
Upstream feeder for the 4-operand compare/sort stage. It collects four operands, delivered serially one nibble per handshake, plus a 3-bit opt word, and presents them in parallel as a stable frame. The outputs drive the sorter's in_n0..in_n3 and opt inputs directly. The frame is released through a valid/ready handshake so the downstream stage (or its output register) can stall the loader.

Parameters:
DATA_W, 4, operand width in bits; must match sorter operand width
OPT_W, 3, opt word width
TIMEOUT_CYC, 15, max idle cycles between operands of one frame (used only with the optional feature); range 1..255

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_data (and in_opt on first operand) valid
in_data  input  DATA_W  serial operand, order n0, n1, n2, n3
in_opt  input  OPT_W  opt word, sampled only with operand n0
in_ready  output  1  loader can accept an operand this cycle
out_valid  output  1  complete frame present on out_n*/out_opt
out_ready  input  1  downstream accepts frame
out_n0  output  DATA_W  operand 0 (first received)
out_n1  output  DATA_W  operand 1
out_n2  output  DATA_W  operand 2
out_n3  output  DATA_W  operand 3 (last received)
out_opt  output  OPT_W  opt word of the frame
frame_cnt  output  8  count of frames delivered, wraps 255->0
abort  output  1  one-cycle pulse when a partial frame is discarded (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, idx=0, out_valid=0, out_n0..3=0, out_opt=0, frame_cnt=0, abort=0, in_ready=1 after reset deasserts.
- Operand accepted when in_valid && in_ready at a rising edge; written to slot idx; idx increments.
- States:
  IDLE: in_ready=1. On accept: store n0 and in_opt, idx=1 -> LOAD.
  LOAD: in_ready=1. On accept: store to slot idx; if idx==3 -> FULL (out_valid=1 next cycle), else idx+1.
  FULL: out_valid=1, outputs stable until handshake. in_ready=out_ready (pass-through accept). On out_valid && out_ready: frame_cnt+1; if an operand is accepted in the same cycle it becomes n0 of the next frame (store n0/opt, idx=1 -> LOAD), else -> IDLE with idx=0.
- out_n* and out_opt are registers; new-frame writes to slots 1..3 must not disturb outputs while out_valid=1. Slot 0/opt overwrite on the release cycle is allowed since out_valid drops the same edge.
- Latency: out_valid rises the cycle after the 4th operand accept; a minimum of 4 cycles per frame at full throughput (no bubble between frames when out_ready=1).
- out_valid never drops without out_ready handshake (except reset).
- in_valid low in LOAD: hold state and idx; no timeout without the optional feature.
- Reset mid-frame: partial frame discarded, no frame_cnt change.
- frame_cnt wraps 8'hFF -> 8'h00 silently.

Optional Feature:
Macro CC_LOADER_TIMEOUT_EN. When defined: an idle counter runs in LOAD, cleared on each accept; if it reaches TIMEOUT_CYC with no accept, the partial frame is discarded, idx=0, state -> IDLE, abort pulses high for exactly one cycle, frame_cnt unchanged; counter inactive in IDLE/FULL. When undefined: no counter logic; abort tied to 0; LOAD waits indefinitely.

Test Plan:
- Reset, then stream 3,9,0,15 with in_opt=3'b101 on first beat, out_ready=1 -> out_valid one cycle after 4th accept, out_n0..3=3,9,0,15, out_opt=5, frame_cnt=1.
- Back-to-back frames, in_valid and out_ready held 1 -> frames every 4 cycles, no bubble, frame 2 operands do not corrupt frame 1 outputs while out_valid=1.
- FULL with out_ready=0 for 5 cycles -> in_ready=0, outputs stable; raise out_ready with in_valid=1, data=7 -> release and 7 stored as next n0.
- Assert rst after 2 operands -> all outputs 0 immediately, next 4 operands form a clean frame, frame_cnt=1.
- Drive 256 frames -> frame_cnt returns to 0.
- (CC_LOADER_TIMEOUT_EN, TIMEOUT_CYC=15) 2 operands then 15 idle cycles -> abort single pulse, next operand taken as n0, frame_cnt unchanged; 14 idle cycles -> no abort.
